// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential divider.
// Optional macro DIV_ZERO_DETECT_EN adds the ZERO early-exit state.
package div_pkg;

  localparam int DW_DEF = 16;
  localparam int CNT_W  = $clog2(2 * DW_DEF);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
`ifdef DIV_ZERO_DETECT_EN
    ,
    ZERO
`endif
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep or restore.
module div_step
  import div_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW:0]   r_i,
  input  logic          q_msb_i,
  input  logic [DW-1:0] d_i,
  output logic [DW:0]   r_o,
  output logic          q_bit_o
);

  logic [DW:0] t;
  logic        unused_r_msb;

  // The partial remainder never exceeds DW bits, so its MSB is dropped.
  assign unused_r_msb = r_i[DW];

  // Trial subtract; a borrow-free result means the quotient bit is 1.
  always_comb begin
    t       = {r_i[DW-1:0], q_msb_i};
    q_bit_o = (t >= {1'b0, d_i});
    r_o     = q_bit_o ? (t - {1'b0, d_i}) : t;
  end

endmodule

// File: rtl/seq_divider_32by16.sv
// Multicycle restoring unsigned divider, 2*DW / DW bits.
// Optional macro DIV_ZERO_DETECT_EN: early exit and div_by_zero flag.
module seq_divider_32by16
  import div_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            done,
  output logic [2*DW-1:0] quotient,
  output logic [DW-1:0]   remainder
`ifdef DIV_ZERO_DETECT_EN
  ,
  output logic            div_by_zero
`endif
);

  localparam int CW = $clog2(2 * DW);
  localparam logic [CW-1:0] LAST = CW'(2 * DW - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2*DW-1:0] q_q, q_d;
  logic [DW-1:0]   d_q, d_d;
  logic [DW:0]     r_q, r_d;
  logic            done_q, done_d;
  logic [2*DW-1:0] quot_q, quot_d;
  logic [DW-1:0]   rem_q, rem_d;
`ifdef DIV_ZERO_DETECT_EN
  logic            dbz_q, dbz_d;
`endif

  logic [DW:0] r_step;
  logic        q_bit;

  div_step #(.DW(DW)) u_step (
    .r_i     (r_q),
    .q_msb_i (q_q[2*DW-1]),
    .d_i     (d_q),
    .r_o     (r_step),
    .q_bit_o (q_bit)
  );

  // Next-state: operand capture, iteration, result latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    done_d  = done_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
`ifdef DIV_ZERO_DETECT_EN
    dbz_d   = dbz_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          q_d     = dividend;
          d_d     = divisor;
          r_d     = '0;
          count_d = '0;
          done_d  = 1'b0;
          state_d = RUN;
`ifdef DIV_ZERO_DETECT_EN
          dbz_d   = 1'b0;
          if (divisor == '0) state_d = ZERO;
`endif
        end
      end
      RUN: begin
        q_d     = {q_q[2*DW-2:0], q_bit};
        r_d     = r_step;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          quot_d  = {q_q[2*DW-2:0], q_bit};
          rem_d   = r_step[DW-1:0];
        end
      end
`ifdef DIV_ZERO_DETECT_EN
      ZERO: begin
        state_d = DONE;
        done_d  = 1'b1;
        quot_d  = '1;
        rem_d   = q_q[DW-1:0];
        dbz_d   = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
`ifdef DIV_ZERO_DETECT_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
`ifdef DIV_ZERO_DETECT_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
`ifdef DIV_ZERO_DETECT_EN
  assign div_by_zero = dbz_q;
`endif

endmodule
